mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Initiator side of the RAM request/response protocol. Arbitrates instruction-fetch
//   and data-memory requests from the core onto the single RAM port. Holds each
//   request stable until the RAM reports RAM_DONE, then returns load data and a
//   one-cycle hit pulse. Alternates grants under contention, with a watchdog timeout.
// PARAMETERS
//   TIMEOUT   64   max cycles in a grant state waiting for RAM_DONE before error (>=2)
// PORTS
//   clk        in   1    system clock, all logic on posedge
//   rst        in   1    synchronous, active-high reset
//   iren       in   1    instruction read request (level, held until ihit)
//   iaddr      in   32   instruction byte address
//   iload      out  32   instruction word, valid while ihit=1
//   ihit       out  1    one-cycle instruction completion pulse
//   dren       in   1    data read request (level, held until dhit)
//   dwen       in   4    data byte write enables (level, held until dhit)
//   daddr      in   32   data byte address
//   dstore     in   32   data write word (byte lanes per dwen)
//   dload      out  32   data read word, valid while dhit=1
//   dhit       out  1    one-cycle data completion pulse
//   err        out  1    high with ihit/dhit when completion was a timeout
//   ram_ren    out  1    RAM read enable
//   ram_wen    out  4    RAM byte write enables
//   ram_addr   out  32   RAM byte address, bits [1:0] forced to 0
//   ram_store  out  32   RAM write data
//   ram_load   in   32   RAM read data
//   ram_state  in   2    ram_state_t (RAM_IDLE / RAM_WAIT / RAM_DONE) from common_types_pkg
// BEHAVIOUR
//   States: ARB_IDLE, ARB_DATA, ARB_INSTR, ARB_RESP. Reset -> ARB_IDLE, last_grant=INSTR,
//     all outputs 0, timeout counter 0. A reset asserted mid-transaction aborts it.
//     Outputs are 0 in the next cycle. No hit pulse is issued for the aborted request.
//   ARB_IDLE: ram_ren=0, ram_wen=0. dreq = dren | (|dwen); ireq = iren.
//     Only dreq -> ARB_DATA. Only ireq -> ARB_INSTR. Neither -> stay.
//     Both -> grant the side opposite last_grant.
//     On grant, latch addr, store, wen and ren into request regs. Set last_grant.
//     Zero the timeout counter.
//   ARB_DATA / ARB_INSTR: ram_* driven only from the latched regs. They hold constant
//     for the whole grant. Requester inputs are ignored.
//     ram_ren = latched_ren & ~|latched_wen, so a write wins if both are set.
//     Instruction grants drive ram_wen=0 and ram_ren=1.
//     ram_state==RAM_DONE: capture ram_load into the response reg, err_n=0 -> ARB_RESP.
//     Otherwise increment the counter. At counter==TIMEOUT-1, load 0 and err_n=1
//     -> ARB_RESP.
//   ARB_RESP: ram_ren=0, ram_wen=0 for exactly one cycle.
//     Raise the granted side's hit with its load and err. The other side's hit=0.
//     -> ARB_IDLE. The requester drops or changes its request at the edge ending
//     ARB_RESP. The next request can therefore be granted no earlier than the
//     following ARB_IDLE cycle.
//   Latency: request visible in ARB_IDLE at cycle 0 -> RAM request at cycle 1
//     -> RAM_DONE at cycle 2+LAT -> hit at cycle 3+LAT -> ARB_IDLE at cycle 4+LAT.
//   Hits are one-hot and never both high. err=0 whenever no hit is asserted.
//   Write completions return dload=0.
//   iload/dload hold their last value when hit=0. Only the hit-cycle value is defined.
// TESTING
//   LAT=0 RAM, dren=1 daddr=0x100 -> ram_ren at cycle 1, dhit=1 at cycle 3,
//     dload=mem[0x40], err=0.
//   dwen=4'b0011 daddr=0x102 dstore=0xAABBCCDD -> ram_addr=0x100, ram_wen=0011.
//     One write only. A later read returns the upper 16 bits unchanged and low
//     half 0xCCDD.
//   iren and dren held continuously from reset -> grants alternate D,I,D,I.
//     Each hit is separated by >=1 ARB_IDLE cycle.
//   RAM stub never returns RAM_DONE, TIMEOUT=8 -> dhit=1 and err=1 exactly 9 cycles
//     after the grant. dload=0. Then back to ARB_IDLE.
//   rst=1 at the cycle of RAM_DONE during a read -> next cycle all outputs 0,
//     ARB_IDLE, no hit pulse.
//   LAT=3 RAM, iren=1 -> ram_ren held for 5 cycles, ihit at cycle 6. Inputs changed
//     mid-grant do not alter ram_addr.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates instruction and data requests onto one RAM port with
// alternating grants under contention and a watchdog timeout per grant.
module mem_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        iren,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        ihit,
  input  logic        dren,
  input  logic [3:0]  dwen,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dhit,
  output logic        err,
  output logic        ram_ren,
  output logic [3:0]  ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_store,
  input  logic [31:0] ram_load,
  input  logic [1:0]  ram_state
);
  typedef enum logic [1:0] {ARB_IDLE, ARB_DATA, ARB_INSTR, ARB_RESP} arb_state_t;
  localparam logic [1:0] RAM_DONE = 2'd2;
  localparam int CW = $clog2(TIMEOUT);
  arb_state_t r_state;
  logic r_last_i;
  logic [CW-1:0] r_cnt;
  logic w_dreq, w_ireq, w_pick_d, w_done, w_tmo;
  logic [31:0] w_addr;
  assign w_dreq = dren | (|dwen);
  assign w_ireq = iren;
  // Under contention the side opposite the previous grant wins.
  assign w_pick_d = w_dreq & (~w_ireq | r_last_i);
  assign w_addr = w_pick_d ? daddr : iaddr;
  assign w_done = ram_state == RAM_DONE;
  assign w_tmo = r_cnt == CW'(TIMEOUT - 1);
  // The ram_* outputs are themselves the latched request; they only change on grant or completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ARB_IDLE;
      r_last_i  <= 1'b1;
      r_cnt     <= '0;
      iload     <= '0;
      ihit      <= 1'b0;
      dload     <= '0;
      dhit      <= 1'b0;
      err       <= 1'b0;
      ram_ren   <= 1'b0;
      ram_wen   <= '0;
      ram_addr  <= '0;
      ram_store <= '0;
    end else begin
      ihit <= 1'b0;
      dhit <= 1'b0;
      err  <= 1'b0;
      case (r_state)
        ARB_IDLE: if (w_dreq | w_ireq) begin
          r_state   <= w_pick_d ? ARB_DATA : ARB_INSTR;
          r_last_i  <= ~w_pick_d;
          r_cnt     <= '0;
          ram_addr  <= {w_addr[31:2], 2'b00};
          ram_store <= w_pick_d ? dstore : '0;
          ram_wen   <= w_pick_d ? dwen : 4'b0;
          ram_ren   <= w_pick_d ? (dren & ~|dwen) : 1'b1;
        end
        ARB_DATA, ARB_INSTR: if (w_done | w_tmo) begin
          r_state <= ARB_RESP;
          ram_ren <= 1'b0;
          ram_wen <= '0;
          err     <= ~w_done;
          if (r_state == ARB_DATA) begin
            dhit  <= 1'b1;
            dload <= (w_done & ~|ram_wen) ? ram_load : '0;
          end else begin
            ihit  <= 1'b1;
            iload <= w_done ? ram_load : '0;
          end
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench with a behavioural RAM of configurable latency.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        iren = 1'b0, dren = 1'b0, ihit, dhit, err, ram_ren;
  logic [3:0]  dwen = '0, ram_wen;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0, iload, dload;
  logic [31:0] ram_addr, ram_store, ram_load;
  logic [1:0]  ram_state;
  logic [31:0] mem [256];
  int lat = 0;
  bit never_done = 1'b0;
  int rcnt, wcount;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .iren(iren), .iaddr(iaddr), .iload(iload), .ihit(ihit),
    .dren(dren), .dwen(dwen), .daddr(daddr), .dstore(dstore), .dload(dload), .dhit(dhit),
    .err(err), .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_store(ram_store), .ram_load(ram_load), .ram_state(ram_state)
  );

  // RAM: answers RAM_DONE lat+1 cycles after it first sees a request, for one cycle.
  always @(posedge clk) begin
    if (rst) begin
      ram_state <= 2'd0;
      rcnt <= 0;
      ram_load <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | i;
    end else if (ram_state == 2'd2 || !(ram_ren || ram_wen != 4'b0)) begin
      ram_state <= 2'd0;
      rcnt <= 0;
    end else if (!never_done && rcnt == lat) begin
      ram_state <= 2'd2;
      rcnt <= 0;
      if (ram_wen != 4'b0) begin
        for (int b = 0; b < 4; b++)
          if (ram_wen[b]) mem[ram_addr[9:2]][8*b +: 8] <= ram_store[8*b +: 8];
        wcount <= wcount + 1;
      end else begin
        ram_load <= mem[ram_addr[9:2]];
      end
    end else begin
      rcnt <= rcnt + 1;
      ram_state <= 2'd1;
    end
  end

  initial wcount = 0;

  task automatic wait_hit(output int cyc);
    cyc = 0;
    while (!(ihit || dhit) && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if ({ihit, dhit, err, ram_ren} !== 4'b0) begin n_fail++; $display("FAIL rst_flags got %b exp 0000", {ihit, dhit, err, ram_ren}); end
    n_checks++; if (ram_wen !== 4'b0) begin n_fail++; $display("FAIL rst_wen got %b exp 0", ram_wen); end
    n_checks++; if ({iload, dload} !== 64'b0) begin n_fail++; $display("FAIL rst_loads got %h exp 0", {iload, dload}); end
    n_checks++; if ({ram_addr, ram_store} !== 64'b0) begin n_fail++; $display("FAIL rst_ram got %h exp 0", {ram_addr, ram_store}); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if ({ihit, dhit, ram_ren} !== 3'b0) begin n_fail++; $display("FAIL rst_idle got %b exp 000", {ihit, dhit, ram_ren}); end
  endtask

  task automatic test_read;
    dren = 1'b1; daddr = 32'h100;
    n_checks++; if (ram_ren !== 1'b0) begin n_fail++; $display("FAIL rd_c0_ren got %b exp 0", ram_ren); end
    @(negedge clk);
    n_checks++; if (ram_ren !== 1'b1) begin n_fail++; $display("FAIL rd_c1_ren got %b exp 1", ram_ren); end
    n_checks++; if (ram_addr !== 32'h100) begin n_fail++; $display("FAIL rd_c1_addr got %h exp 100", ram_addr); end
    repeat (2) @(negedge clk);
    n_checks++; if ({dhit, ihit, err} !== 3'b100) begin n_fail++; $display("FAIL rd_c3_hit got %b exp 100", {dhit, ihit, err}); end
    n_checks++; if (dload !== 32'hA500_0040) begin n_fail++; $display("FAIL rd_dload got %h exp a5000040", dload); end
    dren = 1'b0;
    @(negedge clk);
    n_checks++; if (dhit !== 1'b0) begin n_fail++; $display("FAIL rd_c4_dhit got %b exp 0", dhit); end
  endtask

  task automatic test_write;
    int cyc, w0;
    w0 = wcount;
    dwen = 4'b0011; daddr = 32'h102; dstore = 32'hAABB_CCDD;
    @(negedge clk);
    n_checks++; if (ram_addr !== 32'h100) begin n_fail++; $display("FAIL wr_addr got %h exp 100", ram_addr); end
    n_checks++; if ({ram_wen, ram_ren} !== 5'b00110) begin n_fail++; $display("FAIL wr_en got %b exp 00110", {ram_wen, ram_ren}); end
    n_checks++; if (ram_store !== 32'hAABB_CCDD) begin n_fail++; $display("FAIL wr_store got %h exp aabbccdd", ram_store); end
    wait_hit(cyc);
    n_checks++; if (cyc != 2 || dhit !== 1'b1) begin n_fail++; $display("FAIL wr_hit got cyc %0d dhit %b exp 2 1", cyc, dhit); end
    n_checks++; if (dload !== 32'h0) begin n_fail++; $display("FAIL wr_dload got %h exp 0", dload); end
    dwen = 4'b0; dstore = '0;
    @(negedge clk);
    n_checks++; if (wcount - w0 != 1) begin n_fail++; $display("FAIL wr_count got %0d exp 1", wcount - w0); end
    dren = 1'b1; daddr = 32'h100;
    wait_hit(cyc);
    n_checks++; if (cyc != 3) begin n_fail++; $display("FAIL wr_rb_cyc got %0d exp 3", cyc); end
    n_checks++; if (dload !== 32'hA500_CCDD) begin n_fail++; $display("FAIL wr_rb_data got %h exp a500ccdd", dload); end
    dren = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_alternate;
    int cyc;
    logic [1:0] exp_hits [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    rst = 1'b1; iren = 1'b1; dren = 1'b1; iaddr = 32'h200; daddr = 32'h100;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_hit(cyc);
      n_checks++; if (cyc != 3) begin n_fail++; $display("FAIL alt_cyc%0d got %0d exp 3", k, cyc); end
      n_checks++; if ({ihit, dhit} !== exp_hits[k]) begin n_fail++; $display("FAIL alt_side%0d got %b exp %b", k, {ihit, dhit}, exp_hits[k]); end
      n_checks++; if (ihit ? (iload !== 32'hA500_0080) : (dload !== 32'hA500_0040)) begin n_fail++; $display("FAIL alt_load%0d got %h/%h", k, iload, dload); end
      @(negedge clk);
      n_checks++; if ({ihit, dhit, ram_ren} !== 3'b0) begin n_fail++; $display("FAIL alt_idle%0d got %b exp 000", k, {ihit, dhit, ram_ren}); end
    end
    iren = 1'b0; dren = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_timeout;
    int cyc;
    never_done = 1'b1;
    dren = 1'b1; daddr = 32'h100;
    wait_hit(cyc);
    n_checks++; if (cyc != 9) begin n_fail++; $display("FAIL to_cyc got %0d exp 9", cyc); end
    n_checks++; if ({dhit, ihit, err} !== 3'b101) begin n_fail++; $display("FAIL to_flags got %b exp 101", {dhit, ihit, err}); end
    n_checks++; if (dload !== 32'h0) begin n_fail++; $display("FAIL to_dload got %h exp 0", dload); end
    dren = 1'b0; never_done = 1'b0;
    @(negedge clk);
    n_checks++; if ({dhit, err, ram_ren} !== 3'b0) begin n_fail++; $display("FAIL to_after got %b exp 000", {dhit, err, ram_ren}); end
    dren = 1'b1;
    wait_hit(cyc);
    n_checks++; if (cyc != 3 || err !== 1'b0 || dload !== 32'hA500_0040) begin n_fail++; $display("FAIL to_recover got cyc %0d err %b dload %h exp 3 0 a5000040", cyc, err, dload); end
    dren = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort;
    int c, hits;
    dren = 1'b1; daddr = 32'h100;
    c = 0;
    while (ram_state !== 2'd2 && c < 20) begin
      @(negedge clk);
      c++;
    end
    n_checks++; if (c != 2) begin n_fail++; $display("FAIL ab_done_cyc got %0d exp 2", c); end
    rst = 1'b1; dren = 1'b0;
    @(negedge clk);
    n_checks++; if ({ihit, dhit, err, ram_ren, ram_wen} !== 8'b0) begin n_fail++; $display("FAIL ab_flags got %b exp 0", {ihit, dhit, err, ram_ren, ram_wen}); end
    n_checks++; if ({dload, ram_addr} !== 64'b0) begin n_fail++; $display("FAIL ab_data got %h exp 0", {dload, ram_addr}); end
    rst = 1'b0;
    hits = 0;
    repeat (5) begin
      @(negedge clk);
      if (ihit || dhit || ram_ren) hits++;
    end
    n_checks++; if (hits != 0) begin n_fail++; $display("FAIL ab_nohit got %0d exp 0", hits); end
  endtask

  task automatic test_lat3;
    int c, nren, bad;
    lat = 3;
    iren = 1'b1; iaddr = 32'h203;
    c = 0; nren = 0; bad = 0;
    while (!ihit && c < 20) begin
      @(negedge clk);
      c++;
      if (ram_ren) begin
        nren++;
        if (ram_addr !== 32'h200) bad++;
      end
      if (c == 2) iaddr = 32'h3F0;
    end
    n_checks++; if (c != 6) begin n_fail++; $display("FAIL l3_hit_cyc got %0d exp 6", c); end
    n_checks++; if (nren != 5) begin n_fail++; $display("FAIL l3_ren_cycles got %0d exp 5", nren); end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL l3_addr_changes got %0d exp 0", bad); end
    n_checks++; if (iload !== 32'hA500_0080 || dhit !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL l3_resp got %h %b %b exp a5000080 0 0", iload, dhit, err); end
    iren = 1'b0; lat = 0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset;
    test_read;
    test_write;
    test_alternate;
    test_timeout;
    test_abort;
    test_lat3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
